// File: rtl/apb_reg_slave_if.sv
// APB completer bus bundle for apb_reg_slave: address/control/data from the
// requester, ready/rdata/slv_err back from the completer.
interface apb_reg_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sel;
    logic                  enable;
    logic                  wr_rd;
    logic [31:0]           wdata;
    logic [3:0]            wstrobe;
    logic                  ready;
    logic [31:0]           rdata;
    logic                  slv_err;

    modport master (
        output addr, sel, enable, wr_rd, wdata, wstrobe,
        input  ready, rdata, slv_err
    );

    modport slave (
        input  addr, sel, enable, wr_rd, wdata, wstrobe,
        output ready, rdata, slv_err
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register bank: NR_REGS byte-strobed 32-bit registers with programmable wait states.
// Define APB_REG_SLAVE_SLVERR_EN to report out-of-range/misaligned accesses on slv_err.
module apb_reg_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NR_REGS     = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    apb_reg_slave_if.slave         bus,
    output logic [NR_REGS*32-1:0]  reg_q,
    output logic [NR_REGS-1:0]     wr_pulse
);
    localparam int                    IDX_W = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * NR_REGS);
    localparam logic [3:0]            WS    = 4'(WAIT_STATES);

    logic                  access;
    logic                  ready_int;
    logic                  hit;
    logic                  commit;
    logic [3:0]            cnt_reg;
    logic [3:0]            cnt_next;
    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      idx;
    logic [NR_REGS-1:0]    lane_hit;
    logic [NR_REGS-1:0]    wr_pulse_reg;
    logic [NR_REGS-1:0]    wr_pulse_next;
    logic [31:0]           regs_view [NR_REGS];
    logic [31:0]           rdata_mux;

    assign access    = bus.sel & bus.enable;
    // Reset forces ready low so nothing can complete, or commit, while rst is held.
    assign ready_int = !rst && access && (cnt_reg == WS);
    assign off       = bus.addr - BASE_ADDR;
    assign hit       = (off < SPAN) && (off[1:0] == 2'b00);
    assign idx       = off[IDX_W+1:2];
    assign commit    = ready_int && bus.wr_rd && hit;

    always_comb begin
        cnt_next = 4'd0;
        if (access && !ready_int) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NR_REGS; gi++) begin : g_reg
            logic [31:0] data_reg;

            assign lane_hit[gi] = hit && (idx == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= 32'd0;
                end else if (commit && lane_hit[gi]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.wstrobe[b]) begin
                            data_reg[8*b +: 8] <= bus.wdata[8*b +: 8];
                        end
                    end
                end
            end

            assign regs_view[gi]      = data_reg;
            assign reg_q[32*gi +: 32] = data_reg;
        end
    endgenerate

    // A zero-strobe write still counts as a write for the peripheral's pulse.
    assign wr_pulse_next = commit ? lane_hit : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= wr_pulse_next;
        end
    end

    assign wr_pulse = wr_pulse_reg;

    always_comb begin
        rdata_mux = 32'd0;
        for (int i = 0; i < NR_REGS; i++) begin
            if (lane_hit[i]) begin
                rdata_mux = regs_view[i];
            end
        end
    end

    assign bus.ready = ready_int;
    assign bus.rdata = (ready_int && !bus.wr_rd) ? rdata_mux : 32'd0;

`ifdef APB_REG_SLAVE_SLVERR_EN
    assign bus.slv_err = ready_int && !hit;
`else
    assign bus.slv_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances (WAIT_STATES 0, 2, 3) checked against an
// array-based register model, a constant vector table and hand-written corner sequences.
module tb_apb_reg_slave;
    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam int          NDUT = 3;
`ifdef APB_REG_SLAVE_SLVERR_EN
    localparam bit SLVERR_ON = 1'b1;
`else
    localparam bit SLVERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  t_addr  [NDUT];
    logic         t_sel   [NDUT];
    logic         t_en    [NDUT];
    logic         t_wr    [NDUT];
    logic [31:0]  t_wdata [NDUT];
    logic [3:0]   t_strb  [NDUT];
    logic         t_rst   [NDUT];
    logic         t_ready [NDUT];
    logic [31:0]  t_rdata [NDUT];
    logic         t_err   [NDUT];
    logic [255:0] t_regq  [NDUT];
    logic [7:0]   t_pulse [NDUT];

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            apb_reg_slave_if #(.ADDR_WIDTH(32)) bus ();
            assign bus.addr    = t_addr[gi];
            assign bus.sel     = t_sel[gi];
            assign bus.enable  = t_en[gi];
            assign bus.wr_rd   = t_wr[gi];
            assign bus.wdata   = t_wdata[gi];
            assign bus.wstrobe = t_strb[gi];
            assign t_ready[gi] = bus.ready;
            assign t_rdata[gi] = bus.rdata;
            assign t_err[gi]   = bus.slv_err;

            apb_reg_slave #(
                .ADDR_WIDTH (32),
                .NR_REGS    (8),
                .BASE_ADDR  (BASE),
                .WAIT_STATES(gi == 0 ? 0 : (gi == 1 ? 2 : 3))
            ) dut (
                .clk     (clk),
                .rst     (t_rst[gi]),
                .bus     (bus),
                .reg_q   (t_regq[gi]),
                .wr_pulse(t_pulse[gi])
            );
        end
    endgenerate

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] mdl [NDUT][8];

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mdl_vec(input int k);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = mdl[k][i];
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts at #1 after a rising edge, ends at #1 after the completing edge with the bus idle.
    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] o_rdata, output logic o_err,
                        output logic [7:0] o_pulse);
        logic [31:0] off;
        bit          hit;
        int          idx;
        int          acc;
        bit          done;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_pulse;

        off       = a - BASE;
        hit       = (off < 32) && (off % 4 == 0);
        idx       = hit ? int'(off / 4) : 0;
        exp_rd    = (hit && !wr) ? mdl[k][idx] : 32'd0;
        exp_err   = SLVERR_ON && !hit;
        exp_pulse = (hit && wr) ? 8'(1 << idx) : 8'd0;

        t_sel[k] = 1'b1; t_en[k] = 1'b0; t_wr[k] = wr;
        t_addr[k] = a; t_wdata[k] = d; t_strb[k] = s;
        @(negedge clk);
        chk("setup_ready", 256'(t_ready[k]), 256'(0));
        chk("setup_rdata", 256'(t_rdata[k]), 256'(0));
        @(posedge clk);
        #1 t_en[k] = 1'b1;

        acc = 0; done = 0; o_rdata = '0; o_err = 1'b0;
        while (!done) begin
            @(negedge clk);
            acc++;
            chk("pulse_idle", 256'(t_pulse[k]), 256'(0));
            if (t_ready[k]) begin
                done = 1;
            end else begin
                chk("wait_rdata", 256'(t_rdata[k]), 256'(0));
                chk("wait_slverr", 256'(t_err[k]), 256'(0));
                if (acc > 20) begin
                    chk("ready_timeout", 256'(0), 256'(1));
                    done = 1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        o_rdata = t_rdata[k];
        o_err   = t_err[k];
        chk("access_cycles", 256'(acc), 256'(ws_of(k) + 1));
        chk("rdata", 256'(o_rdata), 256'(exp_rd));
        chk("slv_err", 256'(o_err), 256'(exp_err));

        @(posedge clk);
        #1 t_sel[k] = 1'b0; t_en[k] = 1'b0;
        if (hit && wr) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
        end
        o_pulse = t_pulse[k];
        chk("wr_pulse", 256'(o_pulse), 256'(exp_pulse));
        chk("reg_q", t_regq[k], mdl_vec(k));
        $display("xfer dut=%0d wr=%0d addr=%h wdata=%h strb=%h rdata=%h err=%0d pulse=%b acc=%0d",
                 k, wr, a, d, s, o_rdata, o_err, o_pulse, acc);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] ofs;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          miss;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [7:0]  pl;

        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hA5A5_1234, 4'hF,    32'h0000_0000, 1'b0, 8'h02};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0101, 32'h0000_0000, 1'b0, 8'h02};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF,    32'hA5FF_12FF, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF,    32'h0000_0000, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 32'h0000_0002, 32'hDEAD_BEEF, 4'hF,    32'h0000_0000, 1'b1, 8'h00};
        vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF,    32'hA5FF_12FF, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 32'h0000_001C, 32'h1234_5678, 4'h0,    32'h0000_0000, 1'b0, 8'h80};
        vecs[7]  = '{1'b0, 32'h0000_001C, 32'h0000_0000, 4'hF,    32'h0000_0000, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF,    32'h0000_0000, 1'b1, 8'h00};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'b1000, 32'h0000_0000, 1'b0, 8'h01};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF,    32'h1100_0000, 1'b0, 8'h00};

        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 8; i++) mdl[k][i] = 32'd0;
            t_rst[k] = 1'b1; t_sel[k] = 1'b1; t_en[k] = 1'b1; t_wr[k] = 1'b1;
            t_addr[k] = BASE; t_wdata[k] = 32'hFFFF_FFFF; t_strb[k] = 4'hF;
        end

        // A hit write is presented throughout reset and must be ignored.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                chk("rst_ready", 256'(t_ready[k]), 256'(0));
                chk("rst_rdata", 256'(t_rdata[k]), 256'(0));
                chk("rst_slverr", 256'(t_err[k]), 256'(0));
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            t_rst[k] = 1'b0; t_sel[k] = 1'b0; t_en[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_reg_q", t_regq[k], 256'(0));
            chk("rst_wr_pulse", 256'(t_pulse[k]), 256'(0));
        end
        idle(1);

        for (int v = 0; v < 11; v++) begin
            xfer(0, vecs[v].wr, BASE + vecs[v].ofs, vecs[v].wdata, vecs[v].strb, rd, er, pl);
            chk("vec_rdata", 256'(rd), 256'(vecs[v].exp_rdata));
            chk("vec_slverr", 256'(er), 256'(SLVERR_ON && vecs[v].miss));
            chk("vec_pulse", 256'(pl), 256'(vecs[v].exp_pulse));
            if (v % 3 == 2) idle(1);
        end
        chk("vec_reg1", 256'(t_regq[0][63:32]), 256'(32'hA5FF_12FF));

        // Back-to-back reads on the WAIT_STATES=3 instance; each one checks its own length.
        xfer(2, 1'b1, BASE + 32'h8, 32'h0F0F_A5A5, 4'hF, rd, er, pl);
        xfer(2, 1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, er, pl);
        xfer(2, 1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, er, pl);
        chk("b2b_rdata", 256'(rd), 256'(32'h0F0F_A5A5));

        // Reset in the would-be completing ACCESS cycle of a write (WAIT_STATES=2).
        xfer(1, 1'b1, BASE + 32'hC, 32'hCAFE_F00D, 4'hF, rd, er, pl);
        idle(1);
        t_sel[1] = 1'b1; t_en[1] = 1'b0; t_wr[1] = 1'b1;
        t_addr[1] = BASE + 32'hC; t_wdata[1] = 32'h1234_5678; t_strb[1] = 4'hF;
        idle(1);
        t_en[1] = 1'b1;
        idle(2);
        t_rst[1] = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 256'(t_ready[1]), 256'(0));
        chk("rst_mid_rdata", 256'(t_rdata[1]), 256'(0));
        idle(1);
        @(negedge clk);
        chk("rst_mid_ready2", 256'(t_ready[1]), 256'(0));
        chk("rst_mid_reg_q", t_regq[1], 256'(0));
        idle(1);
        t_rst[1] = 1'b0; t_sel[1] = 1'b0; t_en[1] = 1'b0;
        for (int i = 0; i < 8; i++) mdl[1][i] = 32'd0;
        @(negedge clk);
        chk("rst_mid_pulse", 256'(t_pulse[1]), 256'(0));
        idle(1);
        xfer(1, 1'b0, BASE + 32'hC, 32'h0, 4'hF, rd, er, pl);
        chk("rst_target_read", 256'(rd), 256'(0));

        // sel dropped after the second ACCESS cycle: nothing commits, counter restarts.
        xfer(1, 1'b1, BASE + 32'h14, 32'h1111_2222, 4'hF, rd, er, pl);
        t_sel[1] = 1'b1; t_en[1] = 1'b0; t_wr[1] = 1'b1;
        t_addr[1] = BASE + 32'h14; t_wdata[1] = 32'hAAAA_5555; t_strb[1] = 4'hF;
        idle(1);
        t_en[1] = 1'b1;
        idle(2);
        t_sel[1] = 1'b0;
        @(negedge clk);
        chk("drop_ready", 256'(t_ready[1]), 256'(0));
        idle(1);
        t_en[1] = 1'b0;
        @(negedge clk);
        chk("drop_pulse", 256'(t_pulse[1]), 256'(0));
        chk("drop_reg_q", t_regq[1], mdl_vec(1));
        idle(1);
        xfer(1, 1'b1, BASE + 32'h14, 32'h0BAD_BEEF, 4'hF, rd, er, pl);
        xfer(1, 1'b0, BASE + 32'h14, 32'h0, 4'hF, rd, er, pl);
        chk("drop_after_read", 256'(rd), 256'(32'h0BAD_BEEF));

        for (int n = 0; n < 60; n++) begin
            int          k;
            int          sel_kind;
            logic [31:0] a;
            k        = int'($urandom_range(0, NDUT - 1));
            sel_kind = int'($urandom_range(0, 9));
            if (sel_kind <= 6)      a = BASE + 4 * $urandom_range(0, 7);
            else if (sel_kind == 7) a = BASE + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
            else if (sel_kind == 8) a = BASE + 32 + 4 * $urandom_range(0, 15);
            else                    a = BASE - 4 * $urandom_range(1, 4);
            xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, er, pl);
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
